// File: rtl/fp_positn_serial_mul.sv
// rtl/fp_positn_serial_mul.sv - bit-serial posit(N,ES) weight x FP16 activation multiplier
module fp_positn_serial_mul #(
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int POSIT_MAX = 8,
    parameter int ES        = 0,
    parameter int FRAC_W    = POSIT_MAX - 3,
    parameter int PROD_W    = MAN_WIDTH + FRAC_W + 2,
    parameter int EXPO_W    = EXP_WIDTH + 3,
    parameter int PREC_W    = $clog2(POSIT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACT_WIDTH-1:0] act,
    input  logic                 w_bit,
    input  logic                 valid,
    input  logic                 set,
    input  logic [PREC_W-1:0]    precision,
    output logic                 sign_out,
    output logic [EXPO_W-1:0]    exp_out,
    output logic [PROD_W-1:0]    mantissa_out,
    output logic                 done,
    output logic                 zero_out,
    output logic                 NaR_out
);

    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;

    // Stage-1 collector state
    logic [PREC_W-1:0]    prec_q;
    logic [PREC_W-1:0]    cnt_q;
    logic [POSIT_MAX-1:0] sreg_q;

    // Stage-2 operand register, filled on the last-bit edge
    logic [POSIT_MAX-1:0] s2_word_q;
    logic [ACT_WIDTH-1:0] s2_act_q;
    logic                 s2_valid_q;

    // Collector combinational helpers
    logic [PREC_W-1:0]    prec_clamped;
    logic                 last_bit;
    logic [POSIT_MAX-1:0] word_in;
    logic [PREC_W-1:0]    align_sh;
    logic [POSIT_MAX-1:0] word_aligned;

    // Decode / multiply combinational signals
    logic                 p_zero;
    logic                 p_nar;
    logic                 p_sign;
    logic [POSIT_MAX-1:0] p_abs;
    logic [POSIT_MAX-2:0] p_rem;
    logic                 reg_bit;
    logic                 in_run;
    logic [PREC_W-1:0]    run_len;
    logic [PREC_W-1:0]    skip_len;
    logic [POSIT_MAX-2:0] p_shifted;
    logic [EXPO_W-1:0]    e_val;
    logic [FRAC_W-1:0]    frac;
    logic [EXPO_W-1:0]    k_val;
    logic [EXPO_W-1:0]    scale;
    logic                 a_sign;
    logic [EXP_WIDTH-1:0] a_exp;
    logic [MAN_WIDTH-1:0] a_man;
    logic                 a_zero;
    logic                 a_nar;
    logic [EXPO_W-1:0]    a_unbiased;
    logic                 prod_sign;
    logic [EXPO_W-1:0]    prod_exp;
    logic [PROD_W-1:0]    prod_man;
    logic                 flag_nar;
    logic                 flag_zero;

    // Clamp the requested precision into the legal 2..POSIT_MAX range
    always_comb begin
        prec_clamped = precision;
        if (precision < PREC_W'(2)) begin
            prec_clamped = PREC_W'(2);
        end else if (precision > PREC_W'(POSIT_MAX)) begin
            prec_clamped = PREC_W'(POSIT_MAX);
        end
    end

    // Detect the final bit of a word and left-align the assembled word to POSIT_MAX bits
    always_comb begin
        last_bit     = valid && (cnt_q == (prec_q - PREC_W'(1)));
        word_in      = {sreg_q[POSIT_MAX-2:0], w_bit};
        align_sh     = PREC_W'(POSIT_MAX) - prec_q;
        word_aligned = word_in << align_sh;
    end

    // Precision register; only reloaded while idle between words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prec_q <= PREC_W'(POSIT_MAX);
        end else if (set && (cnt_q == '0) && !valid) begin
            prec_q <= prec_clamped;
        end
    end

    // Serial collector: shift bits in, wrap the counter on the last bit so the next word starts immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else if (valid) begin
            if (last_bit) begin
                cnt_q  <= '0;
                sreg_q <= '0;
            end else begin
                cnt_q  <= cnt_q + PREC_W'(1);
                sreg_q <= word_in;
            end
        end
    end

    // Hand the completed word and its activation to stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_word_q  <= '0;
            s2_act_q   <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= last_bit;
            if (last_bit) begin
                s2_word_q <= word_aligned;
                s2_act_q  <= act;
            end
        end
    end

    // Posit decode: sign-magnitude, regime run length, exponent bits and left-aligned fraction
    always_comb begin
        p_zero  = (s2_word_q == '0);
        p_nar   = (s2_word_q == {1'b1, {(POSIT_MAX-1){1'b0}}});
        p_sign  = s2_word_q[POSIT_MAX-1];
        p_abs   = p_sign ? (~s2_word_q + 1'b1) : s2_word_q;
        p_rem   = p_abs[POSIT_MAX-2:0];
        reg_bit = p_rem[POSIT_MAX-2];

        in_run  = 1'b1;
        run_len = '0;
        for (int i = POSIT_MAX - 2; i >= 0; i--) begin
            if (in_run && (p_rem[i] == reg_bit)) begin
                run_len = run_len + PREC_W'(1);
            end else begin
                in_run = 1'b0;
            end
        end

        // Drop the regime and its terminator; a regime that fills the word shifts everything out
        skip_len  = run_len + PREC_W'(1);
        p_shifted = p_rem << skip_len;

        e_val = '0;
        for (int i = 0; i < ES; i++) begin
            e_val = {e_val[EXPO_W-2:0], p_shifted[POSIT_MAX-2-i]};
        end
        frac = p_shifted[POSIT_MAX-2-ES -: FRAC_W];

        if (reg_bit) begin
            k_val = EXPO_W'(run_len) - EXPO_W'(1);
        end else begin
            k_val = EXPO_W'(0) - EXPO_W'(run_len);
        end
        scale = (k_val << ES) + e_val;
    end

    // FP16 activation decode and the raw product terms
    always_comb begin
        a_sign     = s2_act_q[ACT_WIDTH-1];
        a_exp      = s2_act_q[ACT_WIDTH-2 -: EXP_WIDTH];
        a_man      = s2_act_q[MAN_WIDTH-1:0];
        a_zero     = (a_exp == '0);
        a_nar      = (a_exp == '1);
        a_unbiased = EXPO_W'(a_exp) - EXPO_W'(BIAS);

        prod_sign  = a_sign ^ p_sign;
        prod_exp   = a_unbiased + scale;
        prod_man   = PROD_W'({1'b1, a_man}) * PROD_W'({1'b1, frac});

        flag_nar   = p_nar || a_nar;
        flag_zero  = !flag_nar && (p_zero || a_zero);
    end

    // Result register: one-cycle done strobe, outputs hold between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_out     <= 1'b0;
            exp_out      <= '0;
            mantissa_out <= '0;
            done         <= 1'b0;
            zero_out     <= 1'b0;
            NaR_out      <= 1'b0;
        end else begin
            done <= s2_valid_q;
            if (s2_valid_q) begin
                NaR_out  <= flag_nar;
                zero_out <= flag_zero;
                if (flag_nar || flag_zero) begin
                    sign_out     <= 1'b0;
                    exp_out      <= '0;
                    mantissa_out <= '0;
                end else begin
                    sign_out     <= prod_sign;
                    exp_out      <= prod_exp;
                    mantissa_out <= prod_man;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_positn_serial_mul.sv
// tb/tb_fp_positn_serial_mul.sv - scoreboard bench for fp_positn_serial_mul
module tb_fp_positn_serial_mul;

    localparam int ACT_WIDTH = 16;
    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int POSIT_MAX = 8;
    localparam int ES        = 0;
    localparam int FRAC_W    = POSIT_MAX - 3;
    localparam int PROD_W    = MAN_WIDTH + FRAC_W + 2;
    localparam int EXPO_W    = EXP_WIDTH + 3;
    localparam int PREC_W    = 4;
    localparam int BIAS      = 15;

    logic                 clk;
    logic                 rst;
    logic [ACT_WIDTH-1:0] act;
    logic                 w_bit;
    logic                 valid;
    logic                 set;
    logic [PREC_W-1:0]    precision;
    logic                 sign_out;
    logic [EXPO_W-1:0]    exp_out;
    logic [PROD_W-1:0]    mantissa_out;
    logic                 done;
    logic                 zero_out;
    logic                 NaR_out;

    fp_positn_serial_mul #(
        .ACT_WIDTH(ACT_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH),
        .POSIT_MAX(POSIT_MAX), .ES(ES)
    ) dut (
        .clk(clk), .rst(rst), .act(act), .w_bit(w_bit), .valid(valid),
        .set(set), .precision(precision), .sign_out(sign_out), .exp_out(exp_out),
        .mantissa_out(mantissa_out), .done(done), .zero_out(zero_out), .NaR_out(NaR_out)
    );

    typedef struct {
        int s;
        int ex;
        int man;
        int z;
        int n;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cur_p = POSIT_MAX;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: value-level posit decode on the p-bit word, integer product
    function automatic exp_t model(input int w, input int p, input logic [15:0] a);
        exp_t r;
        int aexp, aman, ws, mag, idx, rb, run, k, e, m, f;
        r = '{default: 0};
        aexp = int'(a[14:10]);
        aman = int'(a[9:0]);
        if (w == (1 << (p - 1)) || aexp == 31) begin
            r.n = 1;
        end else if (w == 0 || aexp == 0) begin
            r.z = 1;
        end else begin
            ws  = (w >> (p - 1)) & 1;
            mag = (ws != 0) ? ((1 << p) - w) : w;
            idx = p - 2;
            rb  = (mag >> idx) & 1;
            run = 0;
            while (idx >= 0 && (((mag >> idx) & 1) == rb)) begin
                run++;
                idx--;
            end
            k = (rb != 0) ? run - 1 : -run;
            idx--;
            e = 0;
            for (int j = 0; j < ES; j++) begin
                e = e * 2 + ((idx >= 0) ? ((mag >> idx) & 1) : 0);
                idx--;
            end
            m = (idx >= 0) ? idx + 1 : 0;
            f = (mag & ((1 << m) - 1)) << (FRAC_W - m);
            r.s   = int'(a[15]) ^ ws;
            r.ex  = aexp - BIAS + k * (1 << ES) + e;
            r.man = ((1 << MAN_WIDTH) + aman) * ((1 << FRAC_W) + f);
        end
        return r;
    endfunction

    // Monitor: every done strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("sb_pending", (sbq.size() > 0) ? 1 : 0, 1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("latency", cyc, mon_e.at);
                chk("nar", NaR_out, mon_e.n);
                chk("zero", zero_out, mon_e.z);
                chk("sign", sign_out, mon_e.s);
                chk("exp", longint'($signed(exp_out)), mon_e.ex);
                chk("mant", mantissa_out, mon_e.man);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prec(input int x);
        valid     = 1'b0;
        set       = 1'b1;
        precision = PREC_W'(x);
        tick();
        set = 1'b0;
        cur_p = (x < 2) ? 2 : ((x > POSIT_MAX) ? POSIT_MAX : x);
    endtask

    task automatic send(input int w, input logic [15:0] a, input int gap_pos, input int gap_len);
        exp_t ex;
        act = a;
        for (int i = 0; i < cur_p; i++) begin
            if (i == gap_pos) begin
                valid = 1'b0;
                repeat (gap_len) tick();
            end
            valid = 1'b1;
            w_bit = ((w >> (cur_p - 1 - i)) & 1) != 0;
            if (i == cur_p - 1) begin
                ex = model(w, cur_p, a);
                ex.at = cyc + 2;
                sbq.push_back(ex);
            end
            tick();
        end
        valid = 1'b0;
    endtask

    initial begin
        int w, p, ex_f, gp;
        logic [15:0] a;
        rst = 1'b1; valid = 1'b0; w_bit = 1'b0; set = 1'b0; precision = '0; act = '0;
        repeat (3) tick();
        chk("reset_outs", {sign_out, exp_out, mantissa_out, done, zero_out, NaR_out}, 0);
        rst = 1'b0;
        tick();

        // Directed cases
        set_prec(4);
        send(4'b0101, 16'h3C00, -1, 0);
        send(4'b1011, 16'h3C00, -1, 0);
        set_prec(8);
        send(8'b01100000, 16'h4000, -1, 0);
        set_prec(4);
        send(4'b0000, 16'h3C00, -1, 0);
        send(4'b1000, 16'h3C00, -1, 0);
        send(4'b0101, 16'h7C00, -1, 0);
        send(4'b0111, 16'hBC00, -1, 0);
        send(4'b0001, 16'h0000, -1, 0);
        // Mid-word stall of 2 cycles
        send(4'b0110, 16'h4A00, 2, 2);

        // set while counter != 0 (and with valid high) is ignored
        act = 16'h3C00;
        valid = 1'b1; w_bit = 1'b0; set = 1'b1; precision = 4'd6;
        tick();
        set = 1'b0; w_bit = 1'b1;
        tick();
        valid = 1'b0; set = 1'b1; precision = 4'd6;
        tick();
        set = 1'b0; valid = 1'b1; w_bit = 1'b0;
        tick();
        w_bit = 1'b1;
        mon_e = model(4'b0101, 4, 16'h3C00);
        mon_e.at = cyc + 2;
        sbq.push_back(mon_e);
        tick();
        valid = 1'b0;
        send(4'b0011, 16'h3555, -1, 0);
        repeat (2) tick();

        // Reset after two bits: partial word discarded, precision back to max
        act = 16'h3C00;
        valid = 1'b1; w_bit = 1'b0;
        tick();
        w_bit = 1'b1;
        tick();
        valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midword_rst_outs", {sign_out, exp_out, mantissa_out, done, zero_out, NaR_out}, 0);
        tick();
        rst = 1'b0;
        cur_p = POSIT_MAX;
        repeat (3) tick();
        chk("post_rst_outs", {sign_out, exp_out, mantissa_out, done, zero_out, NaR_out}, 0);
        send(8'b01100000, 16'h4000, -1, 0);

        // Precision clamping at both ends
        set_prec(1);
        send(2'b01, 16'hC400, -1, 0);
        send(2'b11, 16'h3C01, -1, 0);
        set_prec(12);
        send(8'b10010111, 16'h5123, -1, 0);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 5) == 0) set_prec(int'($urandom_range(0, 15)));
            p = cur_p;
            case ($urandom_range(0, 7))
                0:       w = 0;
                1:       w = 1 << (p - 1);
                default: w = int'($urandom_range(0, (1 << p) - 1));
            endcase
            case ($urandom_range(0, 9))
                0:       ex_f = 0;
                1:       ex_f = 31;
                default: ex_f = int'($urandom_range(1, 30));
            endcase
            a = {1'($urandom_range(0, 1)), 5'(ex_f), 10'($urandom_range(0, 1023))};
            gp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p - 1)) : -1;
            send(w, a, gp, int'($urandom_range(1, 3)));
        end

        repeat (4) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
